// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer driving datapath enables,
// ALU operand/function selects and memory strobes.
module mu0_control (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] IR_op,
  input  logic       N,
  input  logic       Z,
  input  logic       MemRdy,
  output logic       PC_En,
  output logic       IR_En,
  output logic       ACC_En,
  output logic       Addr_sel,
  output logic       X_sel,
  output logic       Y_sel,
  output logic [1:0] ALU_fs,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Outputs are gated by nReset so they drop to 0 the instant reset asserts.
  always_comb begin
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    ACC_En   = 1'b0;
    Addr_sel = 1'b0;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    ALU_fs   = 2'b00;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Halted   = 1'b0;
    state_d  = state_q;

    if (nReset) begin
      case (state_q)
        FETCH: begin
          Rd     = 1'b1;
          X_sel  = 1'b1;
          ALU_fs = 2'b11;
          IR_En  = MemRdy;
          PC_En  = MemRdy;
          if (MemRdy) state_d = EXEC;
        end

        EXEC: begin
          state_d = FETCH;
          case (IR_op)
            4'd0, 4'd2, 4'd3: begin
              Addr_sel = 1'b1;
              Rd       = 1'b1;
              ACC_En   = MemRdy;
              if (IR_op == 4'd2)      ALU_fs = 2'b01;
              else if (IR_op == 4'd3) ALU_fs = 2'b10;
              if (!MemRdy) state_d = EXEC;
            end
            4'd1: begin
              Addr_sel = 1'b1;
              Wr       = 1'b1;
              if (!MemRdy) state_d = EXEC;
            end
            4'd4: begin
              Y_sel = 1'b1;
              PC_En = 1'b1;
            end
            4'd5: begin
              if (!N) begin
                Y_sel = 1'b1;
                PC_En = 1'b1;
              end
            end
            4'd6: begin
              if (!Z) begin
                Y_sel = 1'b1;
                PC_En = 1'b1;
              end
            end
            4'd7:    state_d = HALT;
            default: state_d = FETCH;
          endcase
        end

        HALT: Halted = 1'b1;

        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// Randomized self-checking bench for mu0_control against an instruction-level
// model of the MU0 control sequence.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [3:0] IR_op;
  logic       N, Z, MemRdy;
  logic       PC_En, IR_En, ACC_En, Addr_sel, X_sel, Y_sel;
  logic [1:0] ALU_fs;
  logic       Rd, Wr, Halted;

  int checks = 0;
  int errors = 0;
  int mphase;     // 0 = fetching, 1 = executing, 2 = stopped
  int halt_cnt;

  mu0_control dut (
    .Clk(Clk), .nReset(nReset), .IR_op(IR_op), .N(N), .Z(Z), .MemRdy(MemRdy),
    .PC_En(PC_En), .IR_En(IR_En), .ACC_En(ACC_En), .Addr_sel(Addr_sel),
    .X_sel(X_sel), .Y_sel(Y_sel), .ALU_fs(ALU_fs), .Rd(Rd), .Wr(Wr),
    .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  wire [10:0] obs = {PC_En, IR_En, ACC_En, Addr_sel, X_sel, Y_sel, ALU_fs, Rd, Wr, Halted};

  function automatic logic [10:0] pack(bit pc, bit ir, bit acc, bit asel, bit xs,
                                       bit ys, int fs, bit rd, bit wr, bit h);
    logic [1:0] f;
    f = fs[1:0];
    return {pc, ir, acc, asel, xs, ys, f, rd, wr, h};
  endfunction

  // Expected outputs from the instruction semantics of each phase.
  function automatic logic [10:0] model_out(int ph, int op, bit n, bit z, bit rdy);
    bit is_mem, is_store, taken;
    int fs;
    is_mem   = (op < 4);
    is_store = (op == 1);
    taken    = (op == 4) || (op == 5 && !n) || (op == 6 && !z);
    if (ph == 0) return pack(rdy, rdy, 0, 0, 1, 0, 3, 1, 0, 0);
    if (ph == 2) return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    if (is_mem) begin
      fs = (op == 2) ? 1 : (op == 3) ? 2 : 0;
      return pack(0, 0, !is_store && rdy, 1, 0, 0, fs, !is_store, is_store, 0);
    end
    if (taken) return pack(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    return '0;
  endfunction

  function automatic int model_next(int ph, int op, bit rdy);
    if (ph == 0) return rdy ? 1 : 0;
    if (ph == 2) return 2;
    if (op == 7) return 2;
    if (op < 4 && !rdy) return 1;
    return 0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances one cycle.
  task automatic step(string tag, int op, bit n, bit z, bit rdy);
    IR_op  = op[3:0];
    N      = n;
    Z      = z;
    MemRdy = rdy;
    #4;
    check(tag, {21'd0, obs}, {21'd0, model_out(mphase, op, n, z, rdy)});
    check({tag, "_rdwr"}, {31'd0, Rd & Wr}, 32'd0);
    @(posedge Clk);
    mphase = model_next(mphase, op, rdy);
    #1;
  endtask

  task automatic do_reset(string tag);
    nReset = 1'b0;
    #1;
    mphase = 0;
    check(tag, {21'd0, obs}, 32'd0);
    @(posedge Clk);
    #1;
    nReset = 1'b1;
  endtask

  // Reset dropped between clock edges; outputs must clear before the next edge.
  task automatic async_reset(string tag);
    #2;
    nReset = 1'b0;
    #1;
    check(tag, {21'd0, obs}, 32'd0);
    mphase = 0;
    @(posedge Clk);
    #1;
    check({tag, "_held"}, {21'd0, obs}, 32'd0);
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0;
    IR_op  = 4'd0;
    N      = 1'b0;
    Z      = 1'b0;
    MemRdy = 1'b0;
    mphase = 0;
    #1;
    do_reset("reset");

    // LDA with memory always ready
    step("lda_fetch", 0, 0, 0, 1);
    step("lda_exec", 0, 0, 0, 1);

    // Fetch stalled three cycles, then a NOP
    for (int i = 0; i < 3; i++) step("fetch_stall", 0, 0, 0, 0);
    step("fetch_done", 8, 0, 0, 1);
    step("nop_exec", 8, 0, 0, 0);

    // Conditional jumps
    step("f_jge1", 5, 1, 0, 1);
    step("jge_n1", 5, 1, 0, 1);
    step("f_jge0", 5, 0, 0, 1);
    step("jge_n0", 5, 0, 0, 0);
    step("f_jne1", 6, 0, 1, 1);
    step("jne_z1", 6, 0, 1, 1);
    step("f_jne0", 6, 0, 0, 1);
    step("jne_z0", 6, 0, 0, 0);
    step("f_jmp", 4, 1, 1, 1);
    step("jmp", 4, 1, 1, 0);

    // STA stalled two cycles
    step("f_sta", 1, 0, 0, 1);
    step("sta_stall", 1, 0, 0, 0);
    step("sta_stall", 1, 0, 0, 0);
    step("sta_done", 1, 0, 0, 1);

    // ADD and SUB
    step("f_add", 2, 0, 0, 1);
    step("add", 2, 0, 0, 1);
    step("f_sub", 3, 0, 0, 1);
    step("sub", 3, 0, 0, 1);

    // STP then HALT regardless of MemRdy, released by reset
    step("f_stp", 7, 0, 0, 1);
    step("stp", 7, 0, 0, 1);
    for (int i = 0; i < 12; i++) step("halt", $urandom_range(0, 15), 0, 0, 1'($urandom_range(0, 1)));
    do_reset("halt_reset");
    step("post_halt_fetch", 0, 0, 0, 0);

    // Reset in the middle of a stalled SUB
    step("f_sub2", 3, 0, 0, 1);
    step("sub_stall", 3, 0, 0, 0);
    IR_op  = 4'd3;
    MemRdy = 1'b0;
    async_reset("sub_async_rst");
    step("post_rst_fetch", 3, 0, 0, 1);
    step("post_rst_exec", 3, 0, 0, 1);

    // Randomized run
    halt_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (mphase == 2) halt_cnt++;
      else halt_cnt = 0;
      if ($urandom_range(0, 39) == 0 || halt_cnt > 12) begin
        IR_op  = 4'($urandom_range(0, 15));
        MemRdy = 1'($urandom_range(0, 1));
        async_reset("rnd_rst");
        halt_cnt = 0;
      end else begin
        step("rnd", $urandom_range(0, 15), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
